// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side bundle for hazard_scoreboard: D/E/M register addresses and MD flags in,
// stall, forward selects, MD busy and stall counter out.
interface hazard_scoreboard_if #(
    parameter int AW   = 5,
    parameter int NSTG = 3,
    parameter int TW   = 2
);
    localparam int SW = $clog2(NSTG + 1);

    logic          flush;
    logic [AW-1:0] D_A1;
    logic [AW-1:0] D_A2;
    logic [TW-1:0] D_Tuse_rs;
    logic [TW-1:0] D_Tuse_rt;
    logic [AW-1:0] D_A3;
    logic          D_RegWrite;
    logic [TW-1:0] D_Tnew;
    logic          D_MD;
    logic          D_MDstart;
    logic          D_MDdiv;
    logic [AW-1:0] E_A1;
    logic [AW-1:0] E_A2;
    logic [AW-1:0] M_A2;
    logic          stall;
    logic [SW-1:0] fwdD_rs;
    logic [SW-1:0] fwdD_rt;
    logic [SW-1:0] fwdE_rs;
    logic [SW-1:0] fwdE_rt;
    logic [SW-1:0] fwdM_rt;
    logic          md_busy;
    logic [31:0]   stall_cnt;

    modport master (
        output flush, D_A1, D_A2, D_Tuse_rs, D_Tuse_rt, D_A3, D_RegWrite, D_Tnew,
               D_MD, D_MDstart, D_MDdiv, E_A1, E_A2, M_A2,
        input  stall, fwdD_rs, fwdD_rt, fwdE_rs, fwdE_rt, fwdM_rt, md_busy, stall_cnt
    );

    modport slave (
        input  flush, D_A1, D_A2, D_Tuse_rs, D_Tuse_rt, D_A3, D_RegWrite, D_Tnew,
               D_MD, D_MDstart, D_MDdiv, E_A1, E_A2, M_A2,
        output stall, fwdD_rs, fwdD_rt, fwdE_rs, fwdE_rt, fwdM_rt, md_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Scoreboard-driven hazard unit for the 5-stage MIPS pipeline: stall, forwarding and MD latency.
// Optional feature: define HCU_STALL_CNT_EN to get a 32-bit stalled-cycle counter on stall_cnt.
module hazard_scoreboard #(
    parameter int AW      = 5,
    parameter int NSTG    = 3,
    parameter int TW      = 2,
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10
) (
    input  logic               clk,
    input  logic               reset,
    hazard_scoreboard_if.slave hz
);
    localparam int SW     = $clog2(NSTG + 1);
    localparam int MD_MAX = ((DIV_CYC > MUL_CYC) ? DIV_CYC : MUL_CYC) + 1;
    localparam int CW     = $clog2(MD_MAX + 1);

    typedef struct packed {
        logic          hit;
        logic [SW-1:0] idx;
        logic [TW-1:0] tnew;
    } lookup_t;

    logic          sb_we   [1:NSTG];
    logic [AW-1:0] sb_a3   [1:NSTG];
    logic [TW-1:0] sb_tnew [1:NSTG];
    logic [CW-1:0] md_cnt;

    logic    stall_rs;
    logic    stall_rt;
    logic    stall_md;
    logic    stall;
    lookup_t d_rs;
    lookup_t d_rt;
    lookup_t e_rs;
    lookup_t e_rt;
    lookup_t m_rt;

    // Scanning oldest to youngest lets the youngest producer overwrite any older hit.
    function automatic lookup_t lookup(input logic [AW-1:0] a, input int lo);
        lookup_t r;
        r = '0;
        for (int k = NSTG; k >= 1; k--) begin
            if (k >= lo && sb_we[k] && sb_a3[k] == a && a != '0) begin
                r.hit  = 1'b1;
                r.idx  = SW'(k);
                r.tnew = sb_tnew[k];
            end
        end
        return r;
    endfunction

    always_comb begin
        d_rs     = lookup(hz.D_A1, 1);
        d_rt     = lookup(hz.D_A2, 1);
        e_rs     = lookup(hz.E_A1, 2);
        e_rt     = lookup(hz.E_A2, 2);
        m_rt     = lookup(hz.M_A2, 3);
        stall_rs = d_rs.hit && (d_rs.tnew > hz.D_Tuse_rs);
        stall_rt = d_rt.hit && (d_rt.tnew > hz.D_Tuse_rt);
        stall_md = hz.D_MD && (md_cnt != '0);
        stall    = stall_rs | stall_rt | stall_md;
    end

    assign hz.stall   = stall;
    assign hz.md_busy = (md_cnt != '0);
    assign hz.fwdD_rs = (d_rs.hit && d_rs.tnew == '0) ? d_rs.idx : '0;
    assign hz.fwdD_rt = (d_rt.hit && d_rt.tnew == '0) ? d_rt.idx : '0;
    assign hz.fwdE_rs = (e_rs.hit && e_rs.tnew == '0) ? e_rs.idx : '0;
    assign hz.fwdE_rt = (e_rt.hit && e_rt.tnew == '0) ? e_rt.idx : '0;
    assign hz.fwdM_rt = (m_rt.hit && m_rt.tnew == '0) ? m_rt.idx : '0;

    // A stalled D instruction becomes a bubble in E so it is entered only once, on release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 1; k <= NSTG; k++) begin
                sb_we[k]   <= 1'b0;
                sb_a3[k]   <= '0;
                sb_tnew[k] <= '0;
            end
            md_cnt <= '0;
        end else if (hz.flush) begin
            for (int k = 1; k <= NSTG; k++) begin
                sb_we[k]   <= 1'b0;
                sb_a3[k]   <= '0;
                sb_tnew[k] <= '0;
            end
            md_cnt <= '0;
        end else begin
            if (stall) begin
                sb_we[1]   <= 1'b0;
                sb_a3[1]   <= '0;
                sb_tnew[1] <= '0;
            end else begin
                sb_we[1]   <= hz.D_RegWrite && (hz.D_A3 != '0);
                sb_a3[1]   <= hz.D_A3;
                sb_tnew[1] <= hz.D_Tnew;
            end
            for (int k = 2; k <= NSTG; k++) begin
                sb_we[k]   <= sb_we[k-1];
                sb_a3[k]   <= sb_a3[k-1];
                sb_tnew[k] <= (sb_tnew[k-1] == '0) ? '0 : sb_tnew[k-1] - TW'(1);
            end
            if (hz.D_MDstart && !stall) begin
                md_cnt <= hz.D_MDdiv ? CW'(DIV_CYC + 1) : CW'(MUL_CYC + 1);
            end else if (md_cnt != '0) begin
                md_cnt <= md_cnt - CW'(1);
            end
        end
    end

`ifdef HCU_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Survives flush on purpose so it measures stalls across exceptions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
`else
    assign hz.stall_cnt = '0;
`endif
endmodule
